// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch stage: PC/IR ownership, req/ack instruction-memory fetch,
// and absolute/relative branch target application (immediate or deferred to fetch end).
module sisc_fetch_unit #(
  parameter int PC_W = 16,
  parameter int IW   = 32
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            fetch_go,
  input  logic            br_taken,
  input  logic            br_rel,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic [PC_W-1:0] pc
);

  // Handshake: imem_req rises at the edge leaving IDLE and holds with a
  // constant imem_addr until the edge on which imem_ack=1 is sampled; that
  // edge consumes imem_rdata. An abort (pc_rst) drops the request regardless.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            br_pend_q, br_pend_d;
  logic            br_prel_q, br_prel_d;

  logic [31:0]     imm_sx;
  logic [31:0]     imm_zx;
  logic [PC_W-1:0] tgt_abs;
  logic [PC_W-1:0] tgt_rel;
  logic [PC_W-1:0] pc_inc;
  logic            wait_take;
  logic            wait_rel;

  // Targets always come from the IR currently held, never the word in flight.
  assign imm_sx  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zx  = {16'h0000, ir_q[15:0]};
  assign tgt_abs = imm_zx[PC_W-1:0];
  assign tgt_rel = pc_q + imm_sx[PC_W-1:0];
  assign pc_inc  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // A branch arriving on the completion edge itself is honoured like a latched one.
  assign wait_take = br_pend_q | br_taken;
  assign wait_rel  = br_pend_q ? br_prel_q : br_rel;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      br_pend_q  <= 1'b0;
      br_prel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      br_pend_q  <= br_pend_d;
      br_prel_q  <= br_prel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    br_pend_d  = br_pend_q;
    br_prel_d  = br_prel_q;

    case (state_q)
      S_IDLE: begin
        if (pc_rst) begin
          pc_d      = '0;
          br_pend_d = 1'b0;
        end else begin
          if (br_taken) begin
            pc_d = br_rel ? tgt_rel : tgt_abs;
          end
          // Fetch address follows any branch taken on the same edge.
          if (fetch_go) begin
            state_d = S_WAIT;
            addr_d  = pc_d;
          end
        end
      end
      S_WAIT: begin
        if (pc_rst) begin
          state_d   = S_IDLE;
          pc_d      = '0;
          br_pend_d = 1'b0;
          br_prel_d = 1'b0;
        end else if (imem_ack) begin
          state_d    = S_IDLE;
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          pc_d       = wait_take ? (wait_rel ? tgt_rel : tgt_abs) : pc_inc;
          br_pend_d  = 1'b0;
          br_prel_d  = 1'b0;
        end else if (br_taken) begin
          br_pend_d = 1'b1;
          br_prel_d = br_rel;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req   = (state_q == S_WAIT);
  assign fetch_busy = (state_q == S_WAIT);
  assign imem_addr  = addr_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[31:28];
  assign mm         = ir_q[27:24];
  assign ir_valid   = ir_valid_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: branch vector table plus hand sequences
// for reset, wait states, deferred branches and abort.
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        pc_rst;
  logic        fetch_go;
  logic        br_taken;
  logic        br_rel;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic        ir_valid;
  logic        fetch_busy;
  logic [15:0] pc;

  int errors;
  int checks;

  sisc_fetch_unit #(.PC_W(16), .IW(32)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .fetch_go   (fetch_go),
    .br_taken   (br_taken),
    .br_rel     (br_rel),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .pc         (pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  // One fetch: k wait cycles before ack; optional ignored fetch_go and a
  // mid-WAIT branch pulse in the first wait cycle (requires k >= 1).
  task automatic do_fetch(input logic [15:0] exp_addr, input logic [31:0] word, input int k,
                          input bit go_in_wait, input bit br_in_wait, input bit br_r);
    @(negedge clk);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    chk("req_on", imem_req, 1);
    chk("addr", imem_addr, exp_addr);
    chk("busy_on", fetch_busy, 1);
    for (int i = 0; i < k; i++) begin
      if (i == 0) begin
        fetch_go = go_in_wait;
        br_taken = br_in_wait;
        br_rel   = br_r;
      end
      @(negedge clk);
      fetch_go = 1'b0;
      br_taken = 1'b0;
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, exp_addr);
      chk("busy_hold", fetch_busy, 1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("ir", ir, word);
    chk("ir_valid_pulse", ir_valid, 1);
    chk("req_off", imem_req, 0);
    @(negedge clk);
    chk("ir_valid_drop", ir_valid, 0);
    chk("idle_after", fetch_busy, 0);
  endtask

  task automatic do_branch(input bit rel, input logic [15:0] exp_pc, input string name);
    @(negedge clk);
    br_taken = 1'b1;
    br_rel   = rel;
    @(negedge clk);
    br_taken = 1'b0;
    br_rel   = 1'b0;
    chk(name, pc, exp_pc);
  endtask

  typedef struct {
    logic [15:0] setup_imm;  // absolute branch to this address first
    logic [15:0] br_imm;     // imm16 of the word fetched there
    bit          rel;
    logic [15:0] exp_pc;
  } br_vec_t;

  br_vec_t vecs[4];

  initial begin
    errors     = 0;
    checks     = 0;
    rst_f      = 1'b0;
    pc_rst     = 1'b0;
    fetch_go   = 1'b0;
    br_taken   = 1'b0;
    br_rel     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    vecs[0] = '{16'h0010, 16'h0040, 1'b0, 16'h0040};
    vecs[1] = '{16'h0004, 16'hFFFD, 1'b1, 16'h0002};
    vecs[2] = '{16'hFFFE, 16'h0002, 1'b1, 16'h0001};
    vecs[3] = '{16'h0020, 16'h0010, 1'b1, 16'h0031};

    // reset state
    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", fetch_busy, 0);
    @(negedge clk);
    rst_f = 1'b1;

    // zero-wait sequential fetch
    do_fetch(16'h0000, 32'h1A00_0000, 0, 1'b0, 1'b0, 1'b0);
    chk("opcode", opcode, 4'h1);
    chk("mm", mm, 4'hA);
    do_fetch(16'h0001, 32'h8800_0000, 0, 1'b0, 1'b0, 1'b0);
    chk("opcode2", opcode, 4'h8);
    chk("seq_pc", pc, 16'h0002);

    // wait states with ignored fetch_go
    do_fetch(16'h0002, 32'h3000_0000, 3, 1'b1, 1'b0, 1'b0);
    chk("wait_pc", pc, 16'h0003);
    chk("no_queue_req", imem_req, 0);

    // async reset mid-WAIT
    @(negedge clk);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    chk("pre_rst_req", imem_req, 1);
    #2 rst_f = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pc", pc, 0);
    chk("async_ir", ir, 0);
    chk("async_opcode", opcode, 0);
    chk("async_busy", fetch_busy, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    rst_f    = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", imem_req, 0);
    do_fetch(16'h0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);

    // branch vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      do_fetch(16'h0000, {16'h0000, vecs[v].setup_imm}, 0, 1'b0, 1'b0, 1'b0);
      do_branch(1'b0, vecs[v].setup_imm, "setup_br");
      do_fetch(vecs[v].setup_imm, {16'h0000, vecs[v].br_imm}, 1, 1'b0, 1'b0, 1'b0);
      chk("fetch_inc", pc, vecs[v].setup_imm + 16'h0001);
      do_branch(vecs[v].rel, vecs[v].exp_pc, "vec_br");
    end

    // branch latched during WAIT
    do_reset();
    do_fetch(16'h0000, 32'h0000_0100, 0, 1'b0, 1'b0, 1'b0);
    do_fetch(16'h0001, 32'h0000_0300, 2, 1'b0, 1'b1, 1'b0);
    chk("pend_pc", pc, 16'h0100);
    do_fetch(16'h0100, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);
    chk("pend_next_pc", pc, 16'h0101);

    // abort on same edge as ack, with a branch pending
    do_reset();
    do_fetch(16'h0000, 32'h5000_0200, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    br_taken = 1'b1;
    @(negedge clk);
    br_taken   = 1'b0;
    pc_rst     = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    pc_rst   = 1'b0;
    imem_ack = 1'b0;
    chk("abort_ir", ir, 32'h5000_0200);
    chk("abort_valid", ir_valid, 0);
    chk("abort_pc", pc, 0);
    chk("abort_busy", fetch_busy, 0);
    @(negedge clk);
    chk("abort_valid_late", ir_valid, 0);
    do_fetch(16'h0000, 32'h0000_0077, 0, 1'b0, 1'b0, 1'b0);
    chk("abort_pend_clr", pc, 16'h0001);

    // IDLE priority: branch + fetch together, then pc_rst + fetch together
    @(negedge clk);
    br_taken = 1'b1;
    fetch_go = 1'b1;
    @(negedge clk);
    br_taken = 1'b0;
    fetch_go = 1'b0;
    chk("brgo_pc", pc, 16'h0077);
    chk("brgo_addr", imem_addr, 16'h0077);
    chk("brgo_req", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("brgo_done_pc", pc, 16'h0078);
    pc_rst   = 1'b1;
    fetch_go = 1'b1;
    @(negedge clk);
    pc_rst   = 1'b0;
    fetch_go = 1'b0;
    chk("rstgo_pc", pc, 0);
    chk("rstgo_req", imem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
